// File: rtl/mem1p_access_ctrl_pkg.sv
// Shared constants and helpers for the single-port memory access controller.
package mem1p_access_ctrl_pkg;

  localparam int RD_LAT = 2;   // memory read latency in cycles
  localparam int STAT_W = 32;  // statistics counter width

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem1p_access_ctrl_if.sv
// Client-side request/response handshake bundle of the access controller.
interface mem1p_access_ctrl_if #(
  parameter int AW    = 11,
  parameter int WIDTH = 24
);

  logic             req_valid;
  logic             req_ready;
  logic             req_wnr;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_wnr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_wnr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/mem1p_rsp_fifo.sv
// Read-response FIFO: head entry presented directly, push and pop in the same edge at any occupancy.
module mem1p_rsp_fifo
  import mem1p_access_ctrl_pkg::*;
#(
  parameter  int WIDTH     = 24,
  parameter  int RSP_DEPTH = 4,
  localparam int PW        = clog2_min1(RSP_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop & (r_count != '0);
  // A pop frees the slot in the same edge, so a full FIFO still takes a push.
  assign w_push = i_push & ((r_count != CW'(RSP_DEPTH)) | w_pop);

  // NOTE: storage has no reset; r_count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mem1p_access_ctrl.sv
// Credit-based initiator for a single-port memory with 2-cycle read latency.
// Optional request statistics counters are enabled with MEM1P_ACCESS_CTRL_STAT_EN.
module mem1p_access_ctrl
  import mem1p_access_ctrl_pkg::*;
#(
  parameter  int DEPTH     = 2048,
  parameter  int WIDTH     = 24,
  parameter  int RSP_DEPTH = 4,
  localparam int A         = clog2_min1(DEPTH),
  localparam int CW        = clog2_min1(RSP_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  mem1p_access_ctrl_if.slave cl,
  output logic               mem_me,
  output logic               mem_wnr,
  output logic [A-1:0]       mem_addr,
  output logic [WIDTH-1:0]   mem_din,
  input  logic [WIDTH-1:0]   mem_dout,
  output logic               busy
`ifdef MEM1P_ACCESS_CTRL_STAT_EN
  ,
  input  logic               stat_clr,
  output logic [STAT_W-1:0]  stat_rd_cnt,
  output logic [STAT_W-1:0]  stat_wr_cnt
`endif
);

  logic [RD_LAT-1:0] r_rd_pipe;
  logic [CW-1:0]     w_inflight;
  logic [CW-1:0]     w_fifo_cnt;
  logic [CW:0]       w_used;
  logic              w_credit;
  logic              w_req_ready;
  logic              w_accept;
  logic              w_rd_accept;
  logic              w_wr_accept;

  // NOTE: combinational outputs get a default before the loop so no path can infer a latch.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CW'(r_rd_pipe[i]);
  end

  // Credit is taken from registered counts only, so rsp_ready never reaches req_ready combinationally.
  assign w_used      = (CW+1)'(w_inflight) + (CW+1)'(w_fifo_cnt);
  assign w_credit    = (w_used < (CW+1)'(RSP_DEPTH));
  assign w_req_ready = rst_n & (cl.req_wnr | w_credit);
  assign w_accept    = cl.req_valid & w_req_ready;
  assign w_rd_accept = w_accept & ~cl.req_wnr;
  assign w_wr_accept = w_accept &  cl.req_wnr;

  assign cl.req_ready = w_req_ready;
  assign mem_me       = w_accept;
  assign mem_wnr      = cl.req_wnr;
  assign mem_addr     = cl.req_addr;
  assign mem_din      = cl.req_wdata;

  // Clearing the pipe on reset makes any stale mem_dout arriving afterwards harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_pipe <= '0;
    else        r_rd_pipe <= {r_rd_pipe[RD_LAT-2:0], w_rd_accept};
  end

  mem1p_rsp_fifo #(
    .WIDTH     (WIDTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_rd_pipe[RD_LAT-1]),
    .i_push_data (mem_dout),
    .i_pop       (cl.rsp_ready),
    .o_valid     (cl.rsp_valid),
    .o_data      (cl.rsp_data),
    .o_count     (w_fifo_cnt)
  );

  assign busy = (|r_rd_pipe) | (w_fifo_cnt != '0);

`ifdef MEM1P_ACCESS_CTRL_STAT_EN
  logic [STAT_W-1:0] r_stat_rd_cnt;
  logic [STAT_W-1:0] r_stat_wr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_rd_cnt <= '0;
      r_stat_wr_cnt <= '0;
    end else if (stat_clr) begin
      r_stat_rd_cnt <= '0;
      r_stat_wr_cnt <= '0;
    end else begin
      if (w_rd_accept && (r_stat_rd_cnt != '1)) r_stat_rd_cnt <= r_stat_rd_cnt + STAT_W'(1);
      if (w_wr_accept && (r_stat_wr_cnt != '1)) r_stat_wr_cnt <= r_stat_wr_cnt + STAT_W'(1);
    end
  end

  assign stat_rd_cnt = r_stat_rd_cnt;
  assign stat_wr_cnt = r_stat_wr_cnt;
`endif

endmodule

// File: tb/tb_mem1p_access_ctrl.sv
// Self-checking bench for mem1p_access_ctrl: behavioural memory, scoreboard of expected read data and credit model.
module tb_mem1p_access_ctrl;
  import mem1p_access_ctrl_pkg::*;

  localparam int DEPTH = 2048;
  localparam int W     = 24;
  localparam int RD    = 4;
  localparam int A     = clog2_min1(DEPTH);

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_me;
  logic         mem_wnr;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_din;
  logic [W-1:0] mem_dout;
  logic         busy;
`ifdef MEM1P_ACCESS_CTRL_STAT_EN
  logic         stat_clr = 1'b0;
  logic [31:0]  stat_rd_cnt;
  logic [31:0]  stat_wr_cnt;
`endif

  mem1p_access_ctrl_if #(.AW(A), .WIDTH(W)) cl_if ();

  mem1p_access_ctrl #(.DEPTH(DEPTH), .WIDTH(W), .RSP_DEPTH(RD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cl       (cl_if),
    .mem_me   (mem_me),
    .mem_wnr  (mem_wnr),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy)
`ifdef MEM1P_ACCESS_CTRL_STAT_EN
    ,
    .stat_clr    (stat_clr),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_wr_cnt (stat_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Single-port memory: captures at the issue edge, dout valid one edge later.
  logic [W-1:0] mem_arr [DEPTH];
  logic [W-1:0] mem_q;
  always @(posedge clk) begin
    if (mem_me && mem_wnr)  mem_arr[mem_addr] <= mem_din;
    if (mem_me && !mem_wnr) mem_q <= mem_arr[mem_addr];
    mem_dout <= mem_q;
  end

  // Reference model state
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;
  int           outstanding = 0;
  logic [W-1:0] ref_mem [DEPTH];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           acc_cyc_q[$];
  int           pop_cyc_q[$];

  bit           s_ready, s_valid, s_me, s_wnr, s_busy, s_acc, s_pop;
  logic [W-1:0] s_data;

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    acc_cyc_q.delete();
    pop_cyc_q.delete();
    outstanding = 0;
  endtask

  // Drive one cycle at the falling edge, sample before the next rising edge, update the model.
  task automatic step(input bit v, input bit w, input logic [A-1:0] a,
                      input logic [W-1:0] d, input bit rr);
    @(negedge clk);
    cl_if.req_valid = v;
    cl_if.req_wnr   = w;
    cl_if.req_addr  = a;
    cl_if.req_wdata = d;
    cl_if.rsp_ready = rr;
    #1;
    s_ready = cl_if.req_ready;
    s_valid = cl_if.rsp_valid;
    s_data  = cl_if.rsp_data;
    s_me    = mem_me;
    s_wnr   = mem_wnr;
    s_busy  = busy;
    s_acc   = v && s_ready;
    s_pop   = s_valid && rr;
    if (s_pop) begin
      got_q.push_back(s_data);
      pop_cyc_q.push_back(cyc);
      if (acc_cyc_q.size() > 0) void'(acc_cyc_q.pop_front());
      outstanding--;
    end
    if (s_acc && w) ref_mem[a] = d;
    if (s_acc && !w) begin
      exp_q.push_back(ref_mem[a]);
      acc_cyc_q.push_back(cyc);
      outstanding++;
    end
    cyc++;
  endtask

  task automatic drain(input int max_cyc, output bit timed_out);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < max_cyc) begin
      step(1'b0, 1'b0, '0, '0, 1'b1);
      n++;
    end
    timed_out = (got_q.size() < exp_q.size());
  endtask

  task automatic test_reset();
    cl_if.req_valid = 1'b1;
    cl_if.req_wnr   = 1'b0;
    cl_if.req_addr  = '0;
    cl_if.req_wdata = '0;
    cl_if.rsp_ready = 1'b0;
    #1;
    n_checks++; if (cl_if.req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", cl_if.req_ready); else n_pass++;
    n_checks++; if (cl_if.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", cl_if.rsp_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (mem_me !== 1'b0) $display("FAIL rst_mem_me: got %b want 0", mem_me); else n_pass++;
`ifdef MEM1P_ACCESS_CTRL_STAT_EN
    n_checks++; if (stat_rd_cnt !== 32'd0 || stat_wr_cnt !== 32'd0)
      $display("FAIL rst_stat: got rd=%0d wr=%0d want 0/0", stat_rd_cnt, stat_wr_cnt); else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (cl_if.req_ready !== 1'b1) $display("FAIL rel_req_ready: got %b want 1", cl_if.req_ready); else n_pass++;
    cl_if.req_valid = 1'b0;
  endtask

  task automatic test_write_read();
    clear_model();
    step(1'b1, 1'b1, A'(5), W'(24'hABCDEF), 1'b1);
    n_checks++; if (!(s_acc && s_me && s_wnr))
      $display("FAIL wr_issue: got acc=%b me=%b wnr=%b want 1/1/1", s_acc, s_me, s_wnr); else n_pass++;
    step(1'b1, 1'b0, A'(5), '0, 1'b1);
    n_checks++; if (!(s_acc && s_me && !s_wnr))
      $display("FAIL rd_issue: got acc=%b me=%b wnr=%b want 1/1/0", s_acc, s_me, s_wnr); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1);
      n_checks++; if (s_valid !== (k == 3))
        $display("FAIL rd_latency_c%0d: got rsp_valid=%b want %b", k, s_valid, (k == 3)); else n_pass++;
    end
    n_checks++; if (s_data !== 24'hABCDEF) $display("FAIL rd_data: got %h want abcdef", s_data); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int  n_acc = 0;
    int  t0;
    bit  to;
    clear_model();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, A'(16 + i), W'($urandom), 1'b1);
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, A'(16 + i), '0, 1'b1);
      if (s_acc) n_acc++;
    end
    n_checks++; if (n_acc != 8) $display("FAIL b2b_accepts: got %0d want 8", n_acc); else n_pass++;
    drain(20, to);
    n_checks++; if (to) $display("FAIL b2b_drain_timeout: got %0d responses want %0d", got_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (pop_cyc_q.size() != 8 || pop_cyc_q[0] - t0 != 3 || pop_cyc_q[7] - pop_cyc_q[0] != 7)
      $display("FAIL b2b_timing: got %0d pops first_lat=%0d want 8 pops lat=3 gapless",
               pop_cyc_q.size(), (pop_cyc_q.size() > 0) ? pop_cyc_q[0] - t0 : -1); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL b2b_data[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    bit to;
    clear_model();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, A'(16 + i), '0, 1'b0);
      if (s_acc) n_acc++;
    end
    n_checks++; if (n_acc != RD) $display("FAIL bp_accepts: got %0d want %0d", n_acc, RD); else n_pass++;
    step(1'b1, 1'b1, A'(32), W'(24'h123456), 1'b0);
    n_checks++; if (!s_acc) $display("FAIL bp_write_accept: got %b want 1", s_acc); else n_pass++;
    step(1'b1, 1'b0, A'(16), '0, 1'b0);
    n_checks++; if (s_acc || !s_busy) $display("FAIL bp_read_blocked: got acc=%b busy=%b want 0/1", s_acc, s_busy); else n_pass++;
    step(1'b1, 1'b0, A'(17), '0, 1'b1);
    n_checks++; if (!s_pop || s_ready) $display("FAIL bp_first_pop: got pop=%b ready=%b want 1/0", s_pop, s_ready); else n_pass++;
    step(1'b1, 1'b0, A'(18), '0, 1'b1);
    n_checks++; if (!s_ready) $display("FAIL bp_credit_return: got ready=%b want 1", s_ready); else n_pass++;
    drain(30, to);
    n_checks++; if (to || got_q.size() != RD + 1)
      $display("FAIL bp_drain: got %0d responses want %0d", got_q.size(), RD + 1); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL bp_data[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_full_push_pop();
    bit to;
    clear_model();
    for (int i = 0; i < 5; i++) step(i < 4, 1'b0, A'(20 + i), '0, 1'b0);
    // The fourth read lands in the FIFO on the same edge the head is popped.
    step(1'b1, 1'b0, A'(24), '0, 1'b1);
    n_checks++; if (!s_pop || s_ready) $display("FAIL full_pushpop: got pop=%b ready=%b want 1/0", s_pop, s_ready); else n_pass++;
    drain(20, to);
    n_checks++; if (to || got_q.size() != 4) $display("FAIL full_count: got %0d responses want 4", got_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL full_data[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); else n_pass++;
    end
    step(1'b0, 1'b0, '0, '0, 1'b1);
    n_checks++; if (s_busy || s_valid) $display("FAIL full_idle: got busy=%b valid=%b want 0/0", s_busy, s_valid); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int spurious = 0;
    clear_model();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, A'(16 + i), '0, 1'b0);
    cl_if.req_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (cl_if.rsp_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL midrst_pre: got valid=%b busy=%b want 1/1", cl_if.rsp_valid, busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (cl_if.rsp_valid !== 1'b0 || busy !== 1'b0 || cl_if.req_ready !== 1'b0)
      $display("FAIL midrst_now: got valid=%b busy=%b ready=%b want 0/0/0",
               cl_if.rsp_valid, busy, cl_if.req_ready); else n_pass++;
    #1;
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1);
      if (s_valid || s_busy) spurious++;
    end
    n_checks++; if (spurious != 0 || got_q.size() != 0)
      $display("FAIL midrst_stale: got %0d stale cycles %0d responses want 0/0", spurious, got_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    bit           v, w, rr, exp_ready, exp_valid, to;
    logic [A-1:0] a;
    logic [W-1:0] d;
    int           bad_ready = 0;
    int           bad_valid = 0;
    clear_model();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, A'(i), W'($urandom), 1'b1);
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 3) != 0);
      a  = A'($urandom_range(0, 15));
      d  = W'($urandom);
      exp_ready = w || (outstanding < RD);
      exp_valid = (acc_cyc_q.size() > 0) && (acc_cyc_q[0] + 3 <= cyc);
      step(v, w, a, d, rr);
      n_checks++;
      if (s_ready !== exp_ready) begin
        if (bad_ready < 5) $display("FAIL rnd_ready@%0d: got %b want %b", cyc, s_ready, exp_ready);
        bad_ready++;
      end else n_pass++;
      n_checks++;
      if (s_valid !== exp_valid) begin
        if (bad_valid < 5) $display("FAIL rnd_valid@%0d: got %b want %b", cyc, s_valid, exp_valid);
        bad_valid++;
      end else n_pass++;
    end
    drain(50, to);
    n_checks++; if (to || got_q.size() != exp_q.size())
      $display("FAIL rnd_drain: got %0d responses want %0d", got_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL rnd_data[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]); else n_pass++;
    end
  endtask

`ifdef MEM1P_ACCESS_CTRL_STAT_EN
  task automatic test_stat();
    bit to;
    clear_model();
    stat_clr = 1'b1;
    step(1'b0, 1'b0, '0, '0, 1'b1);
    stat_clr = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, A'(40 + i), W'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, A'(40 + (i % 3)), '0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    n_checks++; if (stat_wr_cnt !== 32'd3 || stat_rd_cnt !== 32'd5)
      $display("FAIL stat_counts: got rd=%0d wr=%0d want 5/3", stat_rd_cnt, stat_wr_cnt); else n_pass++;
    stat_clr = 1'b1;
    step(1'b1, 1'b0, A'(40), '0, 1'b1);
    stat_clr = 1'b0;
    n_checks++; if (!s_acc) $display("FAIL stat_clr_read_accept: got %b want 1", s_acc); else n_pass++;
    step(1'b1, 1'b0, A'(41), '0, 1'b1);
    n_checks++; if (stat_wr_cnt !== 32'd0 || stat_rd_cnt !== 32'd0)
      $display("FAIL stat_clr_priority: got rd=%0d wr=%0d want 0/0", stat_rd_cnt, stat_wr_cnt); else n_pass++;
    step(1'b0, 1'b0, '0, '0, 1'b1);
    n_checks++; if (stat_rd_cnt !== 32'd1) $display("FAIL stat_after_clr: got rd=%0d want 1", stat_rd_cnt); else n_pass++;
    drain(20, to);
    n_checks++; if (to || got_q.size() != exp_q.size())
      $display("FAIL stat_drain: got %0d responses want %0d", got_q.size(), exp_q.size()); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_full_push_pop();
    test_reset_midop();
    test_random();
`ifdef MEM1P_ACCESS_CTRL_STAT_EN
    test_stat();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
